// File: rtl/pr_pipe_pkg.sv
// Shared constants and sizing helpers for the PR boundary decouple pipeline.
package pr_pipe_pkg;

    localparam int unsigned REG_BYPASS = 0;
    localparam int unsigned REG_FWD    = 1;
    localparam int unsigned REG_SKID   = 2;

    // Number of beats the chain can hold: two per skid stage, one per forward stage.
    function automatic int unsigned pipe_depth(input int unsigned reg_type,
                                               input int unsigned reg_len);
        return (reg_type == REG_BYPASS) ? 0 :
               reg_len * ((reg_type == REG_SKID) ? 2 : 1);
    endfunction

    // Occupancy port width; a bypass chain still gets a 1-bit (always zero) port.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pr_pipe_if.sv
// Single-beat valid/ready channel used on both sides of the decouple pipeline.
interface pr_pipe_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pr_pipe_stage.sv
// One register stage of the chain: forward-registered or full skid buffer.
module pr_pipe_stage
    import pr_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned REG_TYPE   = REG_SKID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            held
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    assign m_data  = data_q;
    assign m_valid = valid_q;

    generate
        if (REG_TYPE == REG_FWD) begin : g_fwd
            // Ready passes combinationally from downstream when the register is full.
            assign s_ready = !valid_q || m_ready;
            assign held    = {1'b0, valid_q};

            // Main register load; rst/flush drop the held beat.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_q <= 1'b0;
                end else if (s_ready) begin
                    valid_q <= s_valid;
                end
                if (s_ready && s_valid) begin
                    data_q <= s_data;
                end
            end
        end else begin : g_skid
            logic [DATA_WIDTH-1:0] skid_data;
            logic                  skid_valid;

            // Ready comes straight from a flop, cutting the ready path at every stage.
            assign s_ready = !skid_valid;
            assign held    = 2'(valid_q) + 2'(skid_valid);

            // Valid bits: refill main from skid first, else catch a stalled beat in skid.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_q    <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (!valid_q || m_ready) begin
                    if (skid_valid) begin
                        valid_q    <= 1'b1;
                        skid_valid <= 1'b0;
                    end else begin
                        valid_q <= s_valid;
                    end
                end else if (s_valid && !skid_valid) begin
                    skid_valid <= 1'b1;
                end
            end

            // Payload registers follow the same steering as the valid bits.
            always_ff @(posedge clk) begin
                if (!valid_q || m_ready) begin
                    if (skid_valid) begin
                        data_q <= skid_data;
                    end else if (s_valid) begin
                        data_q <= s_data;
                    end
                end else if (s_valid && !skid_valid) begin
                    skid_data <= s_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pr_decouple_pipe.sv
// Valid/ready pipeline for a PR boundary with flush, input decouple and status counters.
module pr_decouple_pipe
    import pr_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned REG_TYPE       = REG_SKID,
    parameter int unsigned REG_LENGTH     = 1,
    parameter int unsigned DECOUPLE_READY = 1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 decouple,
    pr_pipe_if.slave             s,
    pr_pipe_if.master            m,
    output logic [occ_width(pipe_depth(REG_TYPE, REG_LENGTH))-1:0] occupancy,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned OCC_W = occ_width(pipe_depth(REG_TYPE, REG_LENGTH));
    localparam bit          SINK_READY = (DECOUPLE_READY != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic active;
    logic s_valid_eff;
    logic pipe_ready;

    // Nothing enters while clearing; decouple hides upstream valid and overrides ready.
    assign active      = !rst && !flush;
    assign s_valid_eff = s.valid && !decouple && active;
    assign s.ready     = active && (decouple ? SINK_READY : pipe_ready);

    generate
        if (REG_TYPE == REG_BYPASS) begin : g_bypass
            assign m.data     = s.data;
            assign m.valid    = s_valid_eff;
            assign pipe_ready = m.ready;
            assign occupancy  = '0;
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] c_data  [REG_LENGTH+1];
            logic                  c_valid [REG_LENGTH+1];
            logic                  c_ready [REG_LENGTH+1];
            logic [1:0]            c_held  [REG_LENGTH];

            assign c_data[0]          = s.data;
            assign c_valid[0]         = s_valid_eff;
            assign pipe_ready         = c_ready[0];
            assign c_ready[REG_LENGTH] = m.ready;
            assign m.data             = c_data[REG_LENGTH];
            assign m.valid            = c_valid[REG_LENGTH];

            for (genvar i = 0; i < REG_LENGTH; i++) begin : g_stage
                pr_pipe_stage #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .REG_TYPE   (REG_TYPE)
                ) u_stage (
                    .clk     (clk),
                    .rst     (rst),
                    .flush   (flush),
                    .s_data  (c_data[i]),
                    .s_valid (c_valid[i]),
                    .s_ready (c_ready[i]),
                    .m_data  (c_data[i+1]),
                    .m_valid (c_valid[i+1]),
                    .m_ready (c_ready[i+1]),
                    .held    (c_held[i])
                );
            end

            // Occupancy is the sum of per-stage held counts (all flop-sourced).
            always_comb begin
                occupancy = '0;
                for (int unsigned i = 0; i < REG_LENGTH; i++) begin
                    occupancy = occupancy + OCC_W'(c_held[i]);
                end
            end
        end
    endgenerate

    // Saturating count of beats sunk while decoupled; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (decouple && s.valid && s.ready && (drop_count != CNT_MAX)) begin
            drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

endmodule
